// File: rtl/clk_ctrl_pkg.sv
// Shared types and defaults for the clock-enable controller and its divider.
package clk_ctrl_pkg;

    localparam int DEFAULT_DIV_W       = 8;
    localparam int DEFAULT_RESET_DIV   = 1;
    localparam int DEFAULT_IDLE_CYCLES = 4;
    localparam int DEFAULT_WAKE_CYCLES = 2;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SLEEP = 2'd2,
        WAKE  = 2'd3
    } clk_state_e;

    // States in which the downstream clock must stay gated off.
    function automatic logic is_gated(input clk_state_e s);
        return (s == SLEEP) || (s == WAKE);
    endfunction

endpackage

// File: rtl/clk_div_cnt.sv
// Ratio register, divide counter and registered enable-pulse generation.
module clk_div_cnt #(
    parameter int DIV_W     = 8,
    parameter int RESET_DIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DIV_W-1:0] load_ratio,
    input  logic             enable,
    input  logic             restart,
    input  logic             force_off,
    output logic             pulse
);

    logic [DIV_W-1:0] ratio_reg, ratio_next;
    logic [DIV_W-1:0] cnt_reg, cnt_next;
    logic             pulse_reg, pulse_next;
    logic             ratio_slow;
    logic             wrap;

    always_comb begin
        ratio_next = ratio_reg;
        cnt_next   = cnt_reg;
        pulse_next = pulse_reg;
        ratio_slow = (ratio_reg > DIV_W'(1));
        wrap       = (cnt_reg == ratio_reg - DIV_W'(1));

        if (load) begin
            ratio_next = load_ratio;
            cnt_next   = '0;
        end else if (restart) begin
            cnt_next = '0;
        end else if (enable) begin
            if (!ratio_slow || wrap) begin
                cnt_next = '0;
            end else begin
                cnt_next = cnt_reg + DIV_W'(1);
            end
        end

        // Gating wins over everything; a restart emits the first pulse at once.
        if (force_off) begin
            pulse_next = 1'b0;
        end else if (restart) begin
            pulse_next = 1'b1;
        end else if (load) begin
            pulse_next = (load_ratio <= DIV_W'(1));
        end else if (enable) begin
            pulse_next = !ratio_slow || wrap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ratio_reg <= DIV_W'(RESET_DIV);
            cnt_reg   <= '0;
            pulse_reg <= 1'b1;
        end else begin
            ratio_reg <= ratio_next;
            cnt_reg   <= cnt_next;
            pulse_reg <= pulse_next;
        end
    end

    assign pulse = pulse_reg;

endmodule

// File: rtl/clk_en_ctrl.sv
// Clock-enable controller: programmable divider plus sleep/wake handshake,
// feeding the enable of the clock-gating cell from a flop.
module clk_en_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int DIV_W       = DEFAULT_DIV_W,
    parameter int RESET_DIV   = DEFAULT_RESET_DIV,
    parameter int IDLE_CYCLES = DEFAULT_IDLE_CYCLES,
    parameter int WAKE_CYCLES = DEFAULT_WAKE_CYCLES
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [DIV_W-1:0] div_ratio_i,
    input  logic             div_valid_i,
    output logic             div_ready_o,
    input  logic             sleep_req_i,
    output logic             sleep_ack_o,
    input  logic             busy_i,
    input  logic             wake_i,
    output logic             gate_en_o,
    output logic [1:0]       state_o
);

    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

    clk_state_e        state_reg, state_next;
    logic [IDLE_W-1:0] idle_cnt_reg, idle_cnt_next;
    logic [WAKE_W-1:0] wake_cnt_reg, wake_cnt_next;
    logic              sleep_ack_reg;
    logic              div_ready;
    logic              accept;
    logic              restart;
    logic              div_enable;
    logic              force_off;

    assign div_ready  = (state_reg == RUN) || (state_reg == SLEEP);
    assign accept     = div_valid_i && div_ready;
    assign div_enable = (state_reg == RUN) || (state_reg == DRAIN);
    assign force_off  = is_gated(state_next);

    always_comb begin
        state_next    = state_reg;
        idle_cnt_next = '0;
        wake_cnt_next = '0;
        restart       = 1'b0;
        case (state_reg)
            RUN: begin
                if (sleep_req_i) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // An abort (wake or dropped request) beats a completing idle count.
                if (wake_i || !sleep_req_i) begin
                    state_next = RUN;
                end else if (!busy_i) begin
                    if (idle_cnt_reg == IDLE_LAST) begin
                        state_next = SLEEP;
                    end else begin
                        idle_cnt_next = idle_cnt_reg + IDLE_W'(1);
                    end
                end
            end
            SLEEP: begin
                if (wake_i || !sleep_req_i) begin
                    state_next = WAKE;
                end
            end
            WAKE: begin
                if (wake_cnt_reg == WAKE_LAST) begin
                    state_next = RUN;
                    restart    = 1'b1;
                end else begin
                    wake_cnt_next = wake_cnt_reg + WAKE_W'(1);
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= RUN;
            idle_cnt_reg  <= '0;
            wake_cnt_reg  <= '0;
            sleep_ack_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idle_cnt_reg  <= idle_cnt_next;
            wake_cnt_reg  <= wake_cnt_next;
            sleep_ack_reg <= force_off;
        end
    end

    clk_div_cnt #(
        .DIV_W     (DIV_W),
        .RESET_DIV (RESET_DIV)
    ) u_div (
        .clk        (clk_i),
        .rst_n      (rst_ni),
        .load       (accept),
        .load_ratio (div_ratio_i),
        .enable     (div_enable),
        .restart    (restart),
        .force_off  (force_off),
        .pulse      (gate_en_o)
    );

    assign div_ready_o = div_ready;
    assign sleep_ack_o = sleep_ack_reg;
    assign state_o     = state_reg;

endmodule

// File: tb/tb_clk_en_ctrl.sv
// Bench for clk_en_ctrl: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a phase-based behavioural model.
module tb_clk_en_ctrl;

    localparam int DIV_W       = 8;
    localparam int RESET_DIV   = 1;
    localparam int IDLE_CYCLES = 4;
    localparam int WAKE_CYCLES = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [DIV_W-1:0] div_ratio = '0;
    logic             div_valid = 1'b0;
    logic             div_ready;
    logic             sleep_req = 1'b0;
    logic             sleep_ack;
    logic             busy = 1'b0;
    logic             wake = 1'b0;
    logic             gate_en;
    logic [1:0]       state;

    int checks = 0;
    int failures = 0;

    clk_en_ctrl #(
        .DIV_W       (DIV_W),
        .RESET_DIV   (RESET_DIV),
        .IDLE_CYCLES (IDLE_CYCLES),
        .WAKE_CYCLES (WAKE_CYCLES)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .div_ratio_i (div_ratio),
        .div_valid_i (div_valid),
        .div_ready_o (div_ready),
        .sleep_req_i (sleep_req),
        .sleep_ack_o (sleep_ack),
        .busy_i      (busy),
        .wake_i      (wake),
        .gate_en_o   (gate_en),
        .state_o     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: state as a number, divider as "cycles since reference edge".
    int m_state = 0;
    int m_r = RESET_DIV;
    int m_k = 0;
    bit m_restart_ref = 1'b1;
    int m_idle = 0;
    int m_wake_left = 0;

    task model_reset();
        m_state = 0;
        m_r = RESET_DIV;
        m_k = 0;
        m_restart_ref = 1'b1;
        m_idle = 0;
        m_wake_left = 0;
    endtask

    task model_step();
        int ns;
        bit acc;
        acc = div_valid && (m_state == 0 || m_state == 2);
        ns = m_state;
        m_k++;
        case (m_state)
            0: if (sleep_req) ns = 1;
            1: begin
                if (wake || !sleep_req) begin
                    ns = 0;
                    m_idle = 0;
                end else if (busy) begin
                    m_idle = 0;
                end else begin
                    m_idle++;
                    if (m_idle == IDLE_CYCLES) begin
                        ns = 2;
                        m_idle = 0;
                    end
                end
            end
            2: if (wake || !sleep_req) begin
                ns = 3;
                m_wake_left = WAKE_CYCLES;
            end
            default: begin
                m_wake_left--;
                if (m_wake_left == 0) begin
                    ns = 0;
                    m_k = 0;
                    m_restart_ref = 1'b1;
                end
            end
        endcase
        if (acc) begin
            m_r = int'(div_ratio);
            m_k = 0;
            m_restart_ref = 1'b0;
        end
        m_state = ns;
    endtask

    function automatic int model_gate();
        if (m_state >= 2) return 0;
        if (m_r <= 1) return 1;
        if (m_k % m_r != 0) return 0;
        return (m_restart_ref || m_k > 0) ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            model_step();
            #1;
            if (rst_n) begin
                check("m_state", state, m_state);
                check("m_gate_en", gate_en, model_gate());
                check("m_sleep_ack", sleep_ack, (m_state >= 2) ? 1 : 0);
                check("m_div_ready", div_ready, (m_state == 0 || m_state == 2) ? 1 : 0);
            end
        end
    end

    initial begin
        int n;

        // Reset and release
        repeat (3) @(negedge clk);
        check("rst_gate", gate_en, 1);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rel_gate", gate_en, 1);
        check("rel_ack", sleep_ack, 0);
        check("rel_state", state, 0);
        check("rel_ready", div_ready, 1);
        $display("reset release: gate_en=%0d state=%0d", gate_en, state);

        // Divide by 4, then back to 1
        @(negedge clk);
        div_valid = 1'b1;
        div_ratio = 8'd4;
        @(posedge clk);
        #2;
        check("div4_t0", gate_en, 0);
        @(negedge clk);
        div_valid = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #2;
            check("div4_pulse", gate_en, (i % 4 == 0) ? 1 : 0);
        end
        $display("ratio 4 accepted, 12 cycles checked");
        @(negedge clk);
        div_valid = 1'b1;
        div_ratio = 8'd1;
        @(negedge clk);
        div_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #2;
            check("div1_const", gate_en, 1);
        end
        $display("ratio 1 accepted");

        // Drain blocked by periodic busy, then 4 idle cycles to SLEEP
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            sleep_req = 1'b1;
            busy = (i % 3 == 0);
            @(posedge clk);
            #2;
            check("busy_no_sleep", (state == 2'd2) ? 1 : 0, 0);
        end
        @(negedge clk);
        busy = 1'b1;
        @(negedge clk);
        busy = 1'b0;
        n = 0;
        while (state != 2'd2 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("idle_to_sleep_cycles", n, 4);
        check("sleep_ack", sleep_ack, 1);
        check("sleep_gate", gate_en, 0);
        $display("sleep entered after %0d idle cycles", n);

        // Wake pulse: two WAKE cycles, then RUN
        @(negedge clk);
        wake = 1'b1;
        sleep_req = 1'b0;
        @(posedge clk);
        #2;
        check("wake1_state", state, 3);
        check("wake1_gate", gate_en, 0);
        @(negedge clk);
        wake = 1'b0;
        @(posedge clk);
        #2;
        check("wake2_state", state, 3);
        check("wake2_ack", sleep_ack, 1);
        @(posedge clk);
        #2;
        check("wake_run_state", state, 0);
        check("wake_run_gate", gate_en, 1);
        check("wake_run_ack", sleep_ack, 0);
        $display("wake sequence complete");

        // Wake on the cycle the idle count would complete
        @(negedge clk);
        sleep_req = 1'b1;
        @(posedge clk);
        #2;
        check("drain_entry", state, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        wake = 1'b1;
        @(posedge clk);
        #2;
        check("drain_abort_state", state, 0);
        check("drain_abort_ack", sleep_ack, 0);
        @(negedge clk);
        wake = 1'b0;
        sleep_req = 1'b0;
        $display("drain aborted by wake");

        // Asynchronous reset in SLEEP restores defaults, including R = 1
        @(negedge clk);
        div_valid = 1'b1;
        div_ratio = 8'd5;
        @(negedge clk);
        div_valid = 1'b0;
        sleep_req = 1'b1;
        n = 0;
        while (state != 2'd2 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("sleep2_reached", state, 2);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_gate", gate_en, 1);
        check("arst_ack", sleep_ack, 0);
        check("arst_state", state, 0);
        check("arst_ready", div_ready, 1);
        sleep_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #2;
            check("arst_ratio_default", gate_en, 1);
        end
        $display("async reset in sleep restored defaults");

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) sleep_req = ~sleep_req;
            busy = ($urandom_range(0, 2) == 0);
            wake = ($urandom_range(0, 15) == 0);
            div_valid = ($urandom_range(0, 5) == 0);
            div_ratio = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 6));
        end
        @(negedge clk);
        div_valid = 1'b0;
        $display("random run complete");
        repeat (2) @(posedge clk);
        #3;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
